// File: rtl/wddl_pkg.sv
// Shared definitions for the WDDL precharge/evaluate sequencers:
// sequencer states, sticky error-bit positions and a small sizing helper.
package wddl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } wddl_state_t;

    localparam int ERR_PRE  = 0;
    localparam int ERR_EVAL = 1;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/wddl_dr_check.sv
// Dual-rail integrity checker: flags whether a rail pair vector is fully
// precharged (no rail high) or fully evaluated (every pair complementary).
module wddl_dr_check #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] n,
    output logic             pre_ok,
    output logic             eval_ok
);

    assign pre_ok  = ~|(p | n);
    assign eval_ok = &(p ^ n);

endmodule

// File: rtl/wddl_xor4_seq.sv
// Precharge/evaluate sequencer for a 4-input WDDL XOR array: takes single-rail
// operands, drives dual-rail waves from flops, checks and returns the result.
module wddl_xor4_seq
    import wddl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRE_CYC  = 1,
    parameter int EVAL_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d0_in,
    input  logic [WIDTH-1:0] d1_in,
    input  logic [WIDTH-1:0] d2_in,
    input  logic [WIDTH-1:0] d3_in,
    output logic [WIDTH-1:0] xa_p_out,
    output logic [WIDTH-1:0] xa_n_out,
    output logic [WIDTH-1:0] xb_p_out,
    output logic [WIDTH-1:0] xb_n_out,
    output logic [WIDTH-1:0] xc_p_out,
    output logic [WIDTH-1:0] xc_n_out,
    output logic [WIDTH-1:0] xd_p_out,
    output logic [WIDTH-1:0] xd_n_out,
    input  logic [WIDTH-1:0] x_p_in,
    input  logic [WIDTH-1:0] x_n_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d_out,
    output logic [1:0]       err_out
);

    localparam int CNT_W = $clog2(max_of(PRE_CYC, EVAL_CYC) + 1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] EVAL_LAST = CNT_W'(EVAL_CYC - 1);

    wddl_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] op_a, op_b, op_c, op_d;
    logic             pre_ok;
    logic             eval_ok;

    wddl_dr_check #(.WIDTH(WIDTH)) u_check (
        .p       (x_p_in),
        .n       (x_n_in),
        .pre_ok  (pre_ok),
        .eval_ok (eval_ok)
    );

    // Rails are loaded on the PRE->EVAL edge and cleared on the EVAL->DONE edge,
    // so each rail rises at most once per evaluate wave and never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            d_out     <= '0;
            err_out   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_c      <= '0;
            op_d      <= '0;
            xa_p_out  <= '0;
            xa_n_out  <= '0;
            xb_p_out  <= '0;
            xb_n_out  <= '0;
            xc_p_out  <= '0;
            xc_n_out  <= '0;
            xd_p_out  <= '0;
            xd_n_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= d0_in;
                        op_b     <= d1_in;
                        op_c     <= d2_in;
                        op_d     <= d3_in;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= PRE;
                    end
                end
                PRE: begin
                    if (cnt == PRE_LAST) begin
                        if (!pre_ok) err_out[ERR_PRE] <= 1'b1;
                        cnt      <= '0;
                        state    <= EVAL;
                        xa_p_out <= op_a;
                        xa_n_out <= ~op_a;
                        xb_p_out <= op_b;
                        xb_n_out <= ~op_b;
                        xc_p_out <= op_c;
                        xc_n_out <= ~op_c;
                        xd_p_out <= op_d;
                        xd_n_out <= ~op_d;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                EVAL: begin
                    if (cnt == EVAL_LAST) begin
                        d_out <= x_p_in;
                        if (!eval_ok) err_out[ERR_EVAL] <= 1'b1;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                        xa_p_out  <= '0;
                        xa_n_out  <= '0;
                        xb_p_out  <= '0;
                        xb_n_out  <= '0;
                        xc_p_out  <= '0;
                        xc_n_out  <= '0;
                        xd_p_out  <= '0;
                        xd_n_out  <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
